// File: rtl/grf_bypass_if.sv
// grf_bypass_if: W-stage write port and D-stage read port of the general register file.
// Signals: we/A3/WD/WPC (write side), A1/A2 -> RD1/RD2 (read side), wr_count/last_wpc (trace).
// Modports: master = pipeline side driving addresses/data, slave = register file.
interface grf_bypass_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              we;
  logic [4:0]        A1;
  logic [4:0]        A2;
  logic [4:0]        A3;
  logic [DATA_W-1:0] WD;
  logic [31:0]       WPC;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [CNT_W-1:0]  wr_count;
  logic [31:0]       last_wpc;

  modport master (
    output we, A1, A2, A3, WD, WPC,
    input  RD1, RD2, wr_count, last_wpc
  );

  modport slave (
    input  we, A1, A2, A3, WD, WPC,
    output RD1, RD2, wr_count, last_wpc
  );
endinterface

// File: rtl/grf_bypass.sv
// grf_bypass: 32 x DATA_W general register file, r0 hardwired to zero, two combinational
// read ports, one write port committed on the rising edge (1-edge write, 0-cycle read).
// Ports: clk, reset (sync, active-low), bus (grf_bypass_if.slave). No handshake, never stalls.
// Optional macro GRF_BYPASS_EN: forwards WD to a read port addressing the register being
// committed this cycle, so the forwarding unit needs no W->D path.
module grf_bypass #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  grf_bypass_if.slave bus
);

  logic [DATA_W-1:0] regs_q [32];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [31:0]       wpc_q;
  logic              commit;
  logic [DATA_W-1:0] arr1;
  logic [DATA_W-1:0] arr2;

  // A write to r0 is dropped entirely: no storage update, no count, no trace.
  assign commit = bus.we && (bus.A3 != 5'd0);
  assign cnt_d  = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
      wpc_q <= '0;
    end else if (commit) begin
      regs_q[bus.A3] <= bus.WD;
      cnt_q          <= cnt_d;
      wpc_q          <= bus.WPC;
    end
  end

  assign arr1 = (bus.A1 == 5'd0) ? '0 : regs_q[bus.A1];
  assign arr2 = (bus.A2 == 5'd0) ? '0 : regs_q[bus.A2];

`ifdef GRF_BYPASS_EN
  // Reset gates the bypass too: a write discarded by reset must not be visible.
  logic fwd1;
  logic fwd2;
  assign fwd1 = reset && commit && (bus.A3 == bus.A1);
  assign fwd2 = reset && commit && (bus.A3 == bus.A2);
  assign bus.RD1 = fwd1 ? bus.WD : arr1;
  assign bus.RD2 = fwd2 ? bus.WD : arr2;
`else
  assign bus.RD1 = arr1;
  assign bus.RD2 = arr2;
`endif

  assign bus.wr_count = cnt_q;
  assign bus.last_wpc = wpc_q;

endmodule
